// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential 2x2 matrix multiplier.
// Optional saturation is selected by the MATMUL_SAT_EN macro (see mac_unit).
package matmul_pkg;

    localparam int unsigned DW_DEF = 4;
    localparam int unsigned CW_DEF = 2 * DW_DEF + 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMac  = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef logic [2:0] step_t;

    // Row-major flat index of element [r][c] in a packed 2x2 matrix.
    function automatic int unsigned elem_idx(input logic r, input logic c);
        return (r ? 32'd2 : 32'd0) + (c ? 32'd1 : 32'd0);
    endfunction

    // Extract element k of width w from a packed vector (zero-extended to 32 bits).
    function automatic logic [31:0] get_elem(input logic [127:0] vec,
                                             input int unsigned w,
                                             input int unsigned k);
        logic [127:0] mask;
        logic [127:0] shifted;
        mask    = (128'd1 << w) - 128'd1;
        shifted = (vec >> (k * w)) & mask;
        return shifted[31:0];
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Shared multiply-accumulate unit: DW x DW unsigned multiplier and CW accumulator.
// With MATMUL_SAT_EN defined the sum output saturates to 2^(2*DW)-1.
module mac_unit
    import matmul_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned CW = 2 * DW + 1
) (
    input  logic          clk,
    input  logic          nRST,
    input  logic          i_clear,
    input  logic          i_en,
    input  logic          i_load,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [CW-1:0] o_sum
);

    logic [2*DW-1:0] w_prod;
    logic [CW-1:0]   w_prod_ext;
    logic [CW-1:0]   w_sum_raw;
    logic [CW-1:0]   r_acc;

    assign w_prod     = i_a * i_b;
    assign w_prod_ext = CW'(w_prod);
    assign w_sum_raw  = r_acc + w_prod_ext;

`ifdef MATMUL_SAT_EN
    localparam logic [CW-1:0] SatMax = CW'({(2 * DW){1'b1}});
    assign o_sum = (w_sum_raw > SatMax) ? SatMax : w_sum_raw;
`else
    assign o_sum = w_sum_raw;
`endif

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_load ? w_prod_ext : w_sum_raw;
        end
    end

endmodule

// File: rtl/matmul_seq.sv
// Sequential 2x2 matrix multiplier C = A x B stepping one shared MAC through 8 products.
// Build option MATMUL_SAT_EN saturates each result element (handled inside mac_unit).
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned CW = 2 * DW + 1
) (
    input  logic            clk,
    input  logic            nRST,
    input  logic            start,
    input  logic            clear,
    input  logic [4*DW-1:0] a_in,
    input  logic [4*DW-1:0] b_in,
    output logic [4*CW-1:0] c_out,
    output logic            busy,
    output logic            done,
    output logic            c_valid
);

    state_e          r_state;
    step_t           r_step;
    logic [4*DW-1:0] r_a;
    logic [4*DW-1:0] r_b;
    logic [4*CW-1:0] r_c;
    logic            r_busy;
    logic            r_done;
    logic            r_c_valid;

    logic            w_i;
    logic            w_j;
    logic            w_m;
    logic [1:0]      w_out_idx;
    logic [DW-1:0]   w_a_op;
    logic [DW-1:0]   w_b_op;
    logic            w_mac_en;
    logic [CW-1:0]   w_sum;

    // step = {i, j, m}: output row, output column, inner-product term
    assign w_i       = r_step[2];
    assign w_j       = r_step[1];
    assign w_m       = r_step[0];
    assign w_out_idx = r_step[2:1];

    assign w_a_op   = DW'(get_elem(128'(r_a), DW, elem_idx(w_i, w_m)));
    assign w_b_op   = DW'(get_elem(128'(r_b), DW, elem_idx(w_m, w_j)));
    assign w_mac_en = (r_state == StMac) && !clear;

    mac_unit #(
        .DW (DW),
        .CW (CW)
    ) u_mac (
        .clk     (clk),
        .nRST    (nRST),
        .i_clear (clear),
        .i_en    (w_mac_en),
        .i_load  (!w_m),
        .i_a     (w_a_op),
        .i_b     (w_b_op),
        .o_sum   (w_sum)
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state   <= StIdle;
            r_step    <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_c_valid <= 1'b0;
        end else if (clear) begin
            r_state   <= StIdle;
            r_step    <= '0;
            r_c       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_c_valid <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a       <= a_in;
                        r_b       <= b_in;
                        r_step    <= '0;
                        r_c_valid <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= StMac;
                    end
                end
                StMac: begin
                    // Odd steps finish an inner product; the old c_out element is replaced here.
                    if (w_m) begin
                        r_c[w_out_idx*CW +: CW] <= w_sum;
                    end
                    r_step <= r_step + 3'd1;
                    if (r_step == 3'd7) begin
                        r_state   <= StDone;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_c_valid <= 1'b1;
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign c_out   = r_c;
    assign busy    = r_busy;
    assign done    = r_done;
    assign c_valid = r_c_valid;

endmodule

// File: tb/tb_matmul_seq.sv
// Self-checking bench for matmul_seq: directed scenarios plus random operands vs a matrix model.
// Honours MATMUL_SAT_EN when the build defines it.
module tb_matmul_seq;

    localparam int DW = 4;
    localparam int CW = 2 * DW + 1;

    logic            clk = 1'b0;
    logic            nRST;
    logic            start;
    logic            clear;
    logic [4*DW-1:0] a_in;
    logic [4*DW-1:0] b_in;
    logic [4*CW-1:0] c_out;
    logic            busy;
    logic            done;
    logic            c_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    matmul_seq #(
        .DW (DW),
        .CW (CW)
    ) dut (
        .clk     (clk),
        .nRST    (nRST),
        .start   (start),
        .clear   (clear),
        .a_in    (a_in),
        .b_in    (b_in),
        .c_out   (c_out),
        .busy    (busy),
        .done    (done),
        .c_valid (c_valid)
    );

    function automatic logic [4*DW-1:0] pack4(input int e0, input int e1, input int e2,
                                              input int e3);
        return {4'(e3), 4'(e2), 4'(e1), 4'(e0)};
    endfunction

    // Plain 2x2 matrix product on integers.
    function automatic logic [4*CW-1:0] ref_mul(input logic [4*DW-1:0] a,
                                                input logic [4*DW-1:0] b);
        int am[2][2];
        int bm[2][2];
        int s;
        logic [4*CW-1:0] r;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                am[i][j] = int'(a[(2*i+j)*DW +: DW]);
                bm[i][j] = int'(b[(2*i+j)*DW +: DW]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = am[i][0] * bm[0][j] + am[i][1] * bm[1][j];
`ifdef MATMUL_SAT_EN
                if (s > 255) s = 255;
`endif
                r[(2*i+j)*CW +: CW] = 9'(s);
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then wait (bounded) for done; cycles=-1 on timeout.
    task automatic do_run(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b,
                          output int cycles, output int busy_cnt);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start    = 1'b0;
        cycles   = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && cycles < 40) begin
            tick();
            cycles++;
            if (busy) busy_cnt++;
        end
        if (!done) cycles = -1;
    endtask

    task automatic test_reset();
        nRST  = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #12;
        total++;
        if ({c_out, busy, done, c_valid} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: c_out=%h busy=%b done=%b c_valid=%b, want all 0",
                     c_out, busy, done, c_valid);
        end
        @(negedge clk);
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int cyc, bc;
        logic [4*CW-1:0] exp_c;
        exp_c = {9'd50, 9'd43, 9'd22, 9'd19};
        do_run(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), cyc, bc);
        total++;
        if (cyc !== 9) begin
            bad++;
            $display("FAIL basic_latency: got %0d cycles, want 9", cyc);
        end
        total++;
        if (bc !== 8) begin
            bad++;
            $display("FAIL basic_busy_len: got %0d, want 8", bc);
        end
        total++;
        if (c_out !== exp_c) begin
            bad++;
            $display("FAIL basic_result: got %h, want %h", c_out, exp_c);
        end
        total++;
        if (c_valid !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_flags: c_valid=%b busy=%b, want 1 0", c_valid, busy);
        end
        tick();
        total++;
        if (done !== 1'b0 || c_valid !== 1'b1) begin
            bad++;
            $display("FAIL basic_done_width: done=%b c_valid=%b, want 0 1", done, c_valid);
        end
    endtask

    task automatic test_max();
        int cyc, bc;
        int unsigned want;
`ifdef MATMUL_SAT_EN
        want = 255;
`else
        want = 450;
`endif
        do_run(pack4(15, 15, 15, 15), pack4(15, 15, 15, 15), cyc, bc);
        total++;
        if (cyc !== 9) begin
            bad++;
            $display("FAIL max_latency: got %0d, want 9", cyc);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (c_out[k*CW +: CW] !== 9'(want)) begin
                bad++;
                $display("FAIL max_elem%0d: got %0d, want %0d", k, c_out[k*CW +: CW], want);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int done_t[$];
        logic prev_done;
        prev_done = 1'b0;
        a_in  = pack4(1, 0, 0, 1);
        b_in  = pack4(9, 10, 11, 12);
        start = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (done) done_t.push_back(t);
            total++;
            if (done && prev_done) begin
                bad++;
                $display("FAIL b2b_done_width: done high two cycles at t=%0d", t);
            end
            prev_done = done;
        end
        start = 1'b0;
        total++;
        if (done_t.size() !== 4) begin
            bad++;
            $display("FAIL b2b_done_count: got %0d, want 4", done_t.size());
        end
        for (int k = 1; k < done_t.size(); k++) begin
            total++;
            if (done_t[k] - done_t[k-1] !== 10) begin
                bad++;
                $display("FAIL b2b_spacing: got %0d, want 10", done_t[k] - done_t[k-1]);
            end
        end
        total++;
        if (c_out !== ref_mul(a_in, b_in)) begin
            bad++;
            $display("FAIL b2b_identity: got %h, want %h", c_out, ref_mul(a_in, b_in));
        end
        tick();
        tick();
    endtask

    task automatic test_latch();
        logic [4*DW-1:0] a0, b0;
        int dones;
        a0    = pack4(3, 5, 7, 9);
        b0    = pack4(2, 4, 6, 8);
        a_in  = a0;
        b_in  = b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a_in = '0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (done) dones++;
        end
        total++;
        if (dones !== 1) begin
            bad++;
            $display("FAIL latch_done_count: got %0d, want 1", dones);
        end
        total++;
        if (c_out !== ref_mul(a0, b0)) begin
            bad++;
            $display("FAIL latch_result: got %h, want %h", c_out, ref_mul(a0, b0));
        end
    endtask

    task automatic test_clear();
        int cyc;
        // Clear in idle with a valid result present
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++;
        if (c_out !== '0 || c_valid !== 1'b0) begin
            bad++;
            $display("FAIL clear_idle: c_out=%h c_valid=%b, want 0 0", c_out, c_valid);
        end
        a_in  = pack4(4, 3, 2, 1);
        b_in  = pack4(1, 2, 3, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 4; t++) tick();
        clear = 1'b1;
        start = 1'b1;
        tick();
        total++;
        if ({c_out, busy, done, c_valid} !== '0) begin
            bad++;
            $display("FAIL clear_mac: c_out=%h busy=%b done=%b c_valid=%b, want all 0",
                     c_out, busy, done, c_valid);
        end
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL clear_start_blocked: busy=%b done=%b, want 0 0", busy, done);
        end
        clear = 1'b0;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL clear_then_accept: busy=%b, want 1", busy);
        end
        cyc = 1;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        total++;
        if (!done || c_out !== ref_mul(a_in, b_in)) begin
            bad++;
            $display("FAIL clear_rerun: done=%b got %h, want %h", done, c_out,
                     ref_mul(a_in, b_in));
        end
        tick();
    endtask

    task automatic test_async_reset();
        int cyc, bc;
        logic [4*DW-1:0] a1, b1;
        a_in  = pack4(6, 7, 8, 9);
        b_in  = pack4(9, 8, 7, 6);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2;
        nRST = 1'b0;
        #1;
        total++;
        if ({c_out, busy, done, c_valid} !== '0) begin
            bad++;
            $display("FAIL async_reset: c_out=%h busy=%b done=%b c_valid=%b, want all 0",
                     c_out, busy, done, c_valid);
        end
        @(negedge clk);
        nRST = 1'b1;
        tick();
        a1 = pack4(11, 2, 13, 4);
        b1 = pack4(5, 14, 7, 8);
        do_run(a1, b1, cyc, bc);
        total++;
        if (cyc !== 9 || c_out !== ref_mul(a1, b1)) begin
            bad++;
            $display("FAIL post_reset_run: cycles=%0d got %h, want 9 and %h", cyc, c_out,
                     ref_mul(a1, b1));
        end
        tick();
    endtask

    task automatic test_random();
        int cyc, bc;
        logic [4*DW-1:0] a, b;
        for (int n = 0; n < 20; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            do_run(a, b, cyc, bc);
            total++;
            if (cyc !== 9 || c_out !== ref_mul(a, b)) begin
                bad++;
                $display("FAIL random_%0d: a=%h b=%h cycles=%0d got %h, want 9 and %h",
                         n, a, b, cyc, c_out, ref_mul(a, b));
            end
            if (($urandom & 1) != 0) tick();
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_back_to_back();
        test_latch();
        test_clear();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
